div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle iterative integer divider for DIV/DIVU.
- Sits directly upstream of the execute-stage HI/LO path. The execute stage launches an operation with start, holds the pipeline while busy is high, and captures quotient (LO) and remainder (HI) on done.
- Implements radix-2 restoring division on magnitudes, followed by a one-cycle sign fix-up.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a divide; accepted only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- flush  in  1  abort the in-flight operation (from hazard unit FlushE).
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse; results valid in that cycle.
- quotient  out  WIDTH  LO result.
- remainder  out  WIDTH  HI result.
- div_by_zero  out  1  registered flag for the last completed operation.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - busy = 0, done = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0.
  - Reset has priority over start and flush in any state, including mid-operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with start=1, latch is_signed, sign flags, operand magnitudes (|x| when signed), and divisor==0.
  - Clear the partial remainder; counter = WIDTH; go to RUN.
  - Outputs quotient, remainder and div_by_zero keep their previous values.
- RUN, one iteration per edge:
  - rem' = {rem[WIDTH-2:0], q[WIDTH-1]}.
  - q shifts left.
  - If rem' >= divisor magnitude: subtract it and set q[0] = 1.
  - Counter decrements; at counter = 1 go to FIX.
- FIX, one edge:
  - Quotient is negated if the operand signs differ (signed only).
  - Remainder takes the dividend's sign (signed only).
  - Results are written to the output registers; go to DONE.
- DONE:
  - done = 1 for exactly this cycle; go to IDLE on the next edge.
  - start in the DONE cycle is ignored.
- Latency: start sampled at edge k gives done high in the cycle following edge k+WIDTH+1, i.e. WIDTH+2 cycles after start (34 for WIDTH=32).
  - Latency is fixed and independent of operand values, including divide-by-zero.
- Divide by zero (divisor == 0), overriding the computed values in FIX:
  - quotient = all ones.
  - remainder = dividend (original, unsigned bits).
  - div_by_zero = 1.
- Signed overflow (dividend = 0x80000000, divisor = -1):
  - quotient = 0x80000000, remainder = 0, div_by_zero = 0.
  - Produced by the magnitude arithmetic in WIDTH bits; no special case needed beyond wrap.
- start while busy or in DONE is ignored; no queueing.
- flush:
  - In RUN or FIX, return to IDLE on that edge.
  - No done pulse; output registers unchanged.
  - In IDLE, flush takes priority over a simultaneous start; the start is dropped.
- busy and done are never high together.
- Output registers change only in FIX and on reset.

Decomposition:
- Shared header div_defs.v:
  - state encodings DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_FIX=2'd2, DIV_DONE=2'd3.
  - default WIDTH.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: rem, q_msb, divisor_mag.
  - Outputs: rem_next, q_bit.
  - Instantiated once inside div_unit.
- Sign handling and the FSM stay in div_unit.

Test Plan:
- Unsigned: start, is_signed=0, 100 / 7 → exactly 34 cycles later done=1 for one cycle, quotient=14, remainder=2; busy high for cycles 1..33.
- Signed: -7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / -2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- Divide by zero: 0x00001234 / 0, signed and unsigned → quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1, done still at cycle 34; next normal divide clears div_by_zero.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- Handshake:
  - start pulsed again at cycle 10 of an operation → ignored, first result unaffected, single done.
  - flush at cycle 20 → busy low next cycle, no done, outputs retain prior values.
  - A new start then completes normally.
- Reset mid-operation: assert reset at cycle 15 → next cycle state IDLE, busy=0, done=0, quotient=remainder=0, div_by_zero=0; no done ever appears for the aborted op.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default width and FSM encodings.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on magnitudes (purely combinational).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The compare keeps the bit shifted out of rem, so divisors >= 2^(WIDTH-1) still
  // divide correctly; the difference always fits in WIDTH bits when q_bit is set.
  assign shifted  = {rem, q_msb};
  assign q_bit    = (shifted >= {1'b0, divisor_mag});
  assign rem_next = q_bit ? (shifted[WIDTH-1:0] - divisor_mag) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: WIDTH restoring iterations on magnitudes, then a sign fix-up.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .q_msb       (quo_q[WIDTH-1]),
    .divisor_mag (dvsr_q),
    .rem_next    (step_rem),
    .q_bit       (step_qbit)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (!flush && start) begin
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          zero_d  = (divisor == '0);
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[WIDTH-2:0], step_qbit};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          // A zero divisor leaves |dividend| in rem, so the signed fix-up restores the original bits.
          quotient_d  = zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
          remainder_d = r_neg_q ? -rem_q : rem_q;
          dbz_d       = zero_q;
          state_d     = DIV_DONE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // NOTE: the datapath is loaded on every accepted start, so it needs no reset.
  always_ff @(posedge clock) begin
    cnt_q   <= cnt_d;
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dvsr_q  <= dvsr_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    zero_q  <= zero_d;
  end

  assign busy        = (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign done        = (state_q == DIV_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
